ad_sample_packer: RTL

- Parametrised successor to the fixed 16-to-32 AD sample buffer.
- Accepts ADC samples qualified by a data flag and packs PACK consecutive samples into one wide word.
- Buffers the words in an internal single-clock FIFO and signals when a full read burst is available.
- Adds flush with zero-padding, sticky overflow/underflow flags, burst-ready threshold, and simultaneous push/pop at full.

---
 rtl/ad_sample_packer.sv | 115 +++++++++++
 1 files changed

// File: rtl/ad_sample_packer.sv
// ad_sample_packer: packs PACK ADC samples per word into a DEPTH-word FIFO; defining ADP_DROP_CNT_EN adds a dropped-word counter
module ad_sample_packer #(
    parameter int SAMPLE_W = 16,
    parameter int PACK     = 2,
    parameter int DEPTH    = 16,
    parameter int BURST    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SAMPLE_W-1:0]        sample_in,
    input  logic                       sample_valid,
    input  logic                       flush,
    input  logic                       rd_req,
    input  logic                       clr_flags,
    output logic [SAMPLE_W*PACK-1:0]   rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       burst_ready,
    output logic [$clog2(PACK):0]      lane,
    output logic                       overflow,
    output logic                       underflow
`ifdef ADP_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);
    localparam int W  = SAMPLE_W * PACK;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(PACK) + 1;
    localparam int VW = AW + 1;

    logic [W-1:0]  acc;
    logic [W-1:0]  merged;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          accept;
    logic          drop;

    // Merge the incoming sample into its lane; unfilled lanes of acc are always zero, so flush pads for free
    always_comb begin
        merged = acc;
        for (int k = 0; k < PACK; k++)
            if (sample_valid && lane == LW'(k)) merged[k*SAMPLE_W +: SAMPLE_W] = sample_in;
        push   = (sample_valid && lane == LW'(PACK - 1)) || (flush && (sample_valid || lane != '0));
        pop    = rd_req && !empty;
        accept = push && (!full || pop);
        drop   = push && !accept;
    end

    // Partial-word accumulator; any push (accepted or dropped) restarts at lane 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            acc  <= '0;
        end else if (push) begin
            lane <= '0;
            acc  <= '0;
        end else if (sample_valid) begin
            lane <= lane + LW'(1);
            acc  <= merged;
        end
    end

    // Word storage, left unreset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= merged;
    end

    // Pointers, level and registered read port; at full a same-edge pop reads the old word before it is overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            level <= (accept && !pop) ? level + VW'(1) : (pop && !accept) ? level - VW'(1) : level;
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= drop || (overflow && !clr_flags);
            underflow <= (rd_req && empty) || (underflow && !clr_flags);
        end
    end

`ifdef ADP_DROP_CNT_EN
    // Saturating count of dropped words, restarted by clr_flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else drop_cnt <= clr_flags ? {15'd0, drop} : (drop && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
    end
`endif

    assign empty       = level == '0;
    assign full        = level == VW'(DEPTH);
    assign burst_ready = level >= VW'(BURST);
endmodule
